mb_scanner: RTL and testbench

Frame-to-macroblock scanner that feeds the encoder front end. It reads a raster-stored luma frame from frame memory and re-emits it as 16x16 macroblocks, one pixel per cycle, with macroblock sideband flags. It pauses while the run/hold controller asserts `hold`. It returns a one-cycle `stop` pulse to that controller when the last pixel of the frame has been delivered.

---
 rtl/mb_scanner.sv | 208 ++++++++++++++++++++
 tb/tb_mb_scanner.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mb_scanner.sv
// mb_scanner
//
// Purpose: reads a raster-stored 8-bit luma frame from frame memory and
// re-emits it as 16x16 macroblocks, one pixel per cycle, with macroblock
// sideband flags. Reads pause while the run/hold controller asserts hold.
// A one-cycle stop pulse goes back to that controller together with the
// last pixel of the frame.
//
// Parameters:
//   WIDTH   frame width in pixels (multiple of 16)
//   HEIGHT  frame height in pixels (multiple of 16)
//   ADDR_W  frame memory address width
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   hold       1 = do not issue reads
//   mem_rd     frame memory read strobe (combinational on hold)
//   mem_addr   raster pixel address, derived from the registered counters
//   mem_data   pixel returned one cycle after mem_rd
//   pix        output pixel (mem_data passed straight through)
//   pix_valid  pix is valid
//   mb_start   pix is pixel (0,0) of a macroblock
//   mb_end     pix is pixel (15,15) of a macroblock
//   mb_x/mb_y  macroblock column/row of pix
//   stop       one-cycle pulse on the frame's last pixel
//   busy       scanner is in SCAN or DRAIN
//   frame_num  completed-frame counter (only with MB_SCANNER_FRAME_CNT_EN)
//
// Build option:
//   MB_SCANNER_FRAME_CNT_EN  when defined, adds the 16-bit frame_num output,
//                            which increments in the cycle after each stop
//                            and wraps 65535 -> 0.
//
// FSM states:
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | armed; waits for hold to drop before scanning
//   SCAN     | issues one read per cycle whenever hold is low
//   DRAIN    | last read issued; its pixel (and stop) is on the outputs
//   DONE     | frame finished; needs hold to rise before re-arming

module mb_scanner #(
    parameter int WIDTH  = 352,
    parameter int HEIGHT = 288,
    parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [7:0]        pix,
    output logic              pix_valid,
    output logic              mb_start,
    output logic              mb_end,
    output logic [7:0]        mb_x,
    output logic [7:0]        mb_y,
    output logic              stop,
    output logic              busy
`ifdef MB_SCANNER_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_num
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [7:0]        MBX_LAST = 8'(WIDTH / 16 - 1);
    localparam logic [7:0]        MBY_LAST = 8'(HEIGHT / 16 - 1);
    localparam logic [ADDR_W-1:0] LINE_LEN = ADDR_W'(WIDTH);

    logic [1:0]        state;
    logic [1:0]        state_nxt;

    logic [3:0]        col;
    logic [3:0]        row;
    logic [7:0]        mbx;
    logic [7:0]        mby;

    logic              col_wrap;
    logic              row_wrap;
    logic              mbx_wrap;
    logic              last_addr;

    logic [ADDR_W-1:0] line_idx;

    // ------------------------------------------------------------------
    // Read issue
    // ------------------------------------------------------------------
    assign mem_rd = (state == ST_SCAN) && !hold;

    // Wrap conditions cascade: each counter level wraps only when every
    // faster counter is also at its end.
    assign col_wrap  = (col == 4'd15);
    assign row_wrap  = col_wrap && (row == 4'd15);
    assign mbx_wrap  = row_wrap && (mbx == MBX_LAST);
    assign last_addr = mbx_wrap && (mby == MBY_LAST);

    // Raster address: (mby*16 + row) * WIDTH + mbx*16 + col, all operands
    // widened to ADDR_W before the arithmetic so nothing is truncated.
    assign line_idx = ADDR_W'({mby, 4'b0000}) + ADDR_W'(row);
    assign mem_addr = (line_idx * LINE_LEN) + ADDR_W'({mbx, 4'b0000}) + ADDR_W'(col);

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= 4'd0;
            row <= 4'd0;
            mbx <= 8'd0;
            mby <= 8'd0;
        end else if (mem_rd) begin
            col <= col + 4'd1;
            if (col_wrap) begin
                row <= row + 4'd1;
            end
            if (row_wrap) begin
                mbx <= mbx_wrap ? 8'd0 : mbx + 8'd1;
            end
            if (mbx_wrap) begin
                mby <= last_addr ? 8'd0 : mby + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!hold) begin
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (mem_rd && last_addr) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // stop is seen while hold is still low, so requiring hold
                // to rise here keeps the scanner from restarting on its own.
                if (hold) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign busy = (state == ST_SCAN) || (state == ST_DRAIN);

    // ------------------------------------------------------------------
    // Output stage: registered one cycle behind the read so the sideband
    // lines up with the pixel returned by memory.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid <= 1'b0;
            mb_start  <= 1'b0;
            mb_end    <= 1'b0;
            mb_x      <= 8'd0;
            mb_y      <= 8'd0;
            stop      <= 1'b0;
        end else begin
            pix_valid <= mem_rd;
            mb_start  <= mem_rd && (col == 4'd0) && (row == 4'd0);
            mb_end    <= mem_rd && row_wrap;
            stop      <= mem_rd && last_addr;
            // Macroblock coordinates hold their last value across held cycles.
            if (mem_rd) begin
                mb_x <= mbx;
                mb_y <= mby;
            end
        end
    end

    assign pix = mem_data;

`ifdef MB_SCANNER_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_num <= 16'd0;
        end else if (stop) begin
            frame_num <= frame_num + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mb_scanner.sv
// tb_mb_scanner
//
// Self-checking bench for mb_scanner at WIDTH=32, HEIGHT=32. A frame of
// random pixels sits in a bench-side memory. Expected addresses and
// sideband are computed from the pixel's position in macroblock scan
// order with plain arithmetic. Scenarios: continuous scan, a 5-cycle hold
// after pixel 100, hold alternating every cycle, random hold, and a reset
// at pixel 600. Each frame is followed by idle cycles in DONE and a hold
// pulse to re-arm.

module tb_mb_scanner;

    localparam int W    = 32;
    localparam int H    = 32;
    localparam int NPIX = W * H;
    localparam int MBW  = W / 16;

    logic       clk;
    logic       rst;
    logic       hold;
    logic       mem_rd;
    logic [9:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] pix;
    logic       pix_valid;
    logic       mb_start;
    logic       mb_end;
    logic [7:0] mb_x;
    logic [7:0] mb_y;
    logic       stop;
    logic       busy;
`ifdef MB_SCANNER_FRAME_CNT_EN
    logic [15:0] frame_num;
    logic [15:0] exp_frame;
`endif

    mb_scanner #(
        .WIDTH (W),
        .HEIGHT(H)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .pix      (pix),
        .pix_valid(pix_valid),
        .mb_start (mb_start),
        .mb_end   (mb_end),
        .mb_x     (mb_x),
        .mb_y     (mb_y),
        .stop     (stop),
        .busy     (busy)
`ifdef MB_SCANNER_FRAME_CNT_EN
        ,
        .frame_num(frame_num)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] frame [NPIX];

    // Frame memory: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd === 1'b1) begin
            mem_data <= frame[mem_addr];
        end
    end

    int total;
    int bad;

    // Reference-model state (phase: 0 idle, 1 scanning, 2 drain, 3 done)
    int phase;
    int rd_idx;
    bit prev_rd;
    int prev_idx;
    int last_mb;
    bit after_rst;
    bit stop_due;
    int pv_cnt;
    int stop_cnt;

    // Raster address of the k-th pixel in macroblock scan order.
    function automatic int ref_addr(input int k);
        int mb;
        int w;
        mb = k / 256;
        w  = k % 256;
        return ((mb / MBW) * 16 + w / 16) * W + (mb % MBW) * 16 + (w % 16);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge, advance model.
    task automatic tick(input logic h, input logic r);
        bit exp_rd;
        bit exp_stop;
        hold = h;
        rst  = r;
        @(negedge clk);
        exp_rd   = (phase == 1) && !h;
        exp_stop = prev_rd && (prev_idx == NPIX - 1);
        if (!r) begin
            if (after_rst) begin
                chk("rst_mem_rd", mem_rd, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_pix_valid", pix_valid, 0);
                chk("rst_mb_start", mb_start, 0);
                chk("rst_mb_end", mb_end, 0);
                chk("rst_mb_x", mb_x, 0);
                chk("rst_mb_y", mb_y, 0);
                chk("rst_stop", stop, 0);
                chk("rst_busy", busy, 0);
`ifdef MB_SCANNER_FRAME_CNT_EN
                chk("rst_frame_num", frame_num, 0);
`endif
            end
            chk("mem_rd", mem_rd, exp_rd);
            if (exp_rd) begin
                chk("mem_addr", mem_addr, ref_addr(rd_idx));
            end
            chk("pix_valid", pix_valid, prev_rd);
            chk("stop", stop, exp_stop);
            chk("busy", busy, (phase == 1) || (phase == 2));
            chk("mb_x", mb_x, last_mb % MBW);
            chk("mb_y", mb_y, last_mb / MBW);
            if (prev_rd) begin
                chk("pix", pix, frame[ref_addr(prev_idx)]);
                chk("mb_start", mb_start, (prev_idx % 256) == 0);
                chk("mb_end", mb_end, (prev_idx % 256) == 255);
            end
            if (stop === 1'b1) begin
                chk("stop_mb_end", mb_end, 1);
                chk("stop_mb_x", mb_x, MBW - 1);
                chk("stop_mb_y", mb_y, H / 16 - 1);
            end
`ifdef MB_SCANNER_FRAME_CNT_EN
            chk("frame_num", frame_num, exp_frame);
`endif
            if (pix_valid === 1'b1) pv_cnt++;
            if (stop === 1'b1) stop_cnt++;
        end

        if (r) begin
            phase     = 0;
            rd_idx    = 0;
            prev_rd   = 0;
            prev_idx  = 0;
            last_mb   = 0;
            after_rst = 1;
`ifdef MB_SCANNER_FRAME_CNT_EN
            exp_frame = 16'd0;
`endif
        end else begin
            after_rst = 0;
            if (exp_stop) begin
                stop_due = 1;
`ifdef MB_SCANNER_FRAME_CNT_EN
                exp_frame = exp_frame + 16'd1;
`endif
            end
            prev_rd  = exp_rd;
            prev_idx = rd_idx;
            if (exp_rd) begin
                last_mb = rd_idx / 256;
                rd_idx  = (rd_idx + 1) % NPIX;
            end
            case (phase)
                0: if (!h) phase = 1;
                1: if (exp_rd && prev_idx == NPIX - 1) phase = 2;
                2: phase = 3;
                default: if (h) phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    // mode: 0 continuous, 1 hold 5 cycles after pixel 100,
    //       2 alternating hold, 3 random hold, 4 reset at pixel 600
    task automatic run_frame(input int mode, input string name);
        int  hold_left;
        bit  did;
        int  cyc;
        bit  h;
        hold_left = 0;
        did       = 0;
        cyc       = 0;
        stop_due  = 0;
        pv_cnt    = 0;
        stop_cnt  = 0;
        while (!stop_due && cyc < 6000) begin
            h = 0;
            case (mode)
                1: begin
                    if (!did && rd_idx == 101) begin
                        did       = 1;
                        hold_left = 5;
                    end
                    if (hold_left > 0) begin
                        h = 1;
                        hold_left--;
                    end
                end
                2: h = (cyc % 2) == 1;
                3: h = ($urandom_range(0, 3) == 0);
                default: h = 0;
            endcase
            if (mode == 4 && !did && rd_idx == 600) begin
                did = 1;
                tick(1'b0, 1'b1);
                pv_cnt   = 0;
                stop_cnt = 0;
            end else begin
                tick(h, 1'b0);
            end
            cyc++;
        end
        chk({name, "_frame_end"}, stop_due, 1);
        // DONE with hold still low: must not restart.
        repeat (8) tick(1'b0, 1'b0);
        chk({name, "_pix_count"}, pv_cnt, NPIX);
        chk({name, "_stop_count"}, stop_cnt, 1);
        // Re-arm.
        tick(1'b1, 1'b0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        phase     = 0;
        rd_idx    = 0;
        prev_rd   = 0;
        prev_idx  = 0;
        last_mb   = 0;
        after_rst = 0;
        stop_due  = 0;
        pv_cnt    = 0;
        stop_cnt  = 0;
`ifdef MB_SCANNER_FRAME_CNT_EN
        exp_frame = 16'd0;
`endif
        for (int i = 0; i < NPIX; i++) begin
            frame[i] = 8'($urandom_range(0, 255));
        end
        rst  = 1'b1;
        hold = 1'b1;

        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);

        run_frame(0, "continuous");
        run_frame(1, "hold5");
        run_frame(2, "alternate");
        run_frame(3, "random_hold");
        run_frame(4, "reset600");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
